regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port CPU integer register file: NUM_READ synchronous read ports and NUM_WRITE write ports.
//  Optional write-to-read bypass and a per-register busy scoreboard for pending results.
//  Sits between decode (reads, busy marking) and writeback (writes) in copperv_cpu.
//  Register 0 is hardwired to zero when ZERO_REG=1.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  REG_WIDTH   5   address width; depth REG_LENGTH = 2**REG_WIDTH
//  NUM_READ    2   number of read ports (1..4)
//  NUM_WRITE   1   number of write ports (1..2)
//  BYPASS      1   1 = a read sees a same-cycle write; 0 = a read sees the old value
//  ZERO_REG    1   1 = reg 0 reads as 0, writes and busy-set to it are ignored
// PORTS
//  clk            in   1                     clock, all state on posedge
//  rst            in   1                     synchronous reset, active-low
//  wr_en          in   NUM_WRITE             per-port write enable
//  wr_addr        in   NUM_WRITE*REG_WIDTH   write addresses, port k at [k*REG_WIDTH +: REG_WIDTH]
//  wr_data        in   NUM_WRITE*DATA_WIDTH  write data, packed the same way
//  rd_en          in   NUM_READ              per-port read enable
//  rd_addr        in   NUM_READ*REG_WIDTH    read addresses
//  rd_data        out  NUM_READ*DATA_WIDTH   registered read data
//  rd_busy        out  NUM_READ              registered: the addressed register had a pending write at read time
//  busy_set_en    in   1                     mark busy_set_addr as pending (issued producer)
//  busy_set_addr  in   REG_WIDTH             register to mark
//  busy_vec       out  REG_LENGTH            current scoreboard, bit i = reg i pending
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all mem entries, rd_data, rd_busy and busy_vec go to 0.
//    Reset overrides every other input that cycle.
//  - Write: at posedge with wr_en[k]=1, mem[wr_addr[k]] <= wr_data[k].
//    When wr_addr[k]=0 and ZERO_REG=1 the write is dropped.
//    Two ports writing the same address: the highest port index wins.
//  - Read: 1-cycle latency. With rd_en[j]=1 at edge N, rd_data[j] holds the value from edge N+1 onward.
//    With rd_en[j]=0, rd_data[j] and rd_busy[j] hold their previous values.
//    Reads are independent of writes: a write never suppresses a read.
//  - Bypass, BYPASS=1: if rd_addr[j] matches an enabled write this cycle, rd_data[j] <= that wr_data.
//    The highest-index matching write port wins. BYPASS=0: rd_data[j] <= the pre-write mem value.
//  - Zero reg: with ZERO_REG=1, a read of address 0 returns 0 and rd_busy 0, regardless of bypass.
//  - Scoreboard:
//      - An enabled write to reg i clears busy_vec[i].
//      - busy_set_en sets busy_vec[busy_set_addr].
//      - Set and clear on the same reg in the same cycle: set wins (a new producer is issued).
//      - busy_set to reg 0 is ignored when ZERO_REG=1.
//  - rd_busy[j] captures busy_vec[rd_addr[j]] after same-cycle clears, before same-cycle sets.
//    So a bypassed write reports not busy.
//  - busy_vec is a registered output. It is updated at the edge and visible in the following cycle.
//  - Reset asserted mid-operation discards all in-flight reads, writes and sets in that cycle.
// STRUCTURE
//  - Shared package copperv_cpu_pkg: DATA_WIDTH/REG_WIDTH defaults and a function
//    reg_idx(addr, width) for packed-slice indexing.
//  - One sub-module, regfile_read_port (instantiated NUM_READ times via generate):
//    address mux, bypass priority compare across write ports, zero-reg gating, busy capture.
//  - Top level holds mem, busy_vec and the write/scoreboard update loops.
// TESTING
//  1. Reset: hold rst=0 for 2 cycles after random writes -> all reads return 0, busy_vec=0, rd_busy=0.
//  2. Basic: write r5=0xDEADBEEF; next cycle read r5 on port 0 and r0 on port 1
//     -> 0xDEADBEEF and 0 one cycle later.
//  3. Bypass: same-cycle write r7=0x1234 and read r7 (old value 0x55)
//     -> 0x1234 with BYPASS=1, 0x55 with BYPASS=0.
//  4. Zero reg: write r0=0xFFFFFFFF and busy_set r0 -> reading r0 gives 0, busy_vec[0]=0.
//  5. Scoreboard:
//     - busy_set r3 -> busy_vec[3]=1 next cycle; read r3 -> rd_busy=1.
//     - Write r3 with busy_set r3 in the same cycle -> busy_vec[3] stays 1.
//     - A later plain write to r3 -> busy_vec[3]=0.
//  6. NUM_WRITE=2, both ports write r9 (0xA, 0xB) -> r9=0xB; a bypassed read of r9 returns 0xB;
//     rd_en=0 on the next cycle -> rd_data holds 0xB.

Source files
------------

// File: rtl/copperv_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : copperv_cpu_pkg
//  Description : Shared defaults and helpers for the copperv_cpu core. Holds
//                the default register file geometry and a helper that turns a
//                lane index into a bit offset inside a packed bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package copperv_cpu_pkg;

    localparam int c_default_data_width = 32;
    localparam int c_default_reg_width  = 5;

    // Bit offset of lane 'addr' in a packed bus whose lanes are 'width' bits wide
    function automatic int reg_idx(input int addr, input int width);
        return addr * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One synchronous read port of the register file. Selects the
//                addressed register, applies same-cycle write bypass (highest
//                write port wins), forces register 0 to zero when enabled and
//                captures the scoreboard bit for the addressed register.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import copperv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int REG_WIDTH  = c_default_reg_width,
    parameter int REG_LENGTH = 2 ** REG_WIDTH,
    parameter int NUM_WRITE  = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_en,
    input  logic [REG_WIDTH-1:0]             rd_addr,
    input  logic [REG_LENGTH*DATA_WIDTH-1:0] mem_flat,
    input  logic [REG_LENGTH-1:0]            busy_vec,
    input  logic [NUM_WRITE-1:0]             wr_en,
    input  logic [NUM_WRITE*REG_WIDTH-1:0]   wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_busy
);

    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_byp_data;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic                  w_is_zero;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_busy_next;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_busy;

    // Address mux, bypass priority compare, zero-register gating and busy capture
    always_comb begin
        w_hit      = 1'b0;
        w_byp_data = '0;
        w_mem_data = mem_flat[reg_idx(int'(rd_addr), DATA_WIDTH) +: DATA_WIDTH];
        // Ascending scan: the last (highest-index) matching port overrides
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_en[k] && (wr_addr[reg_idx(k, REG_WIDTH) +: REG_WIDTH] == rd_addr)) begin
                w_hit      = 1'b1;
                w_byp_data = wr_data[reg_idx(k, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
        w_is_zero = (ZERO_REG != 0) && (rd_addr == '0);
        if (w_is_zero) begin
            w_data_next = '0;
            w_busy_next = 1'b0;
        end else begin
            w_data_next = ((BYPASS != 0) && w_hit) ? w_byp_data : w_mem_data;
            // A same-cycle write clears the pending bit before any new set lands
            w_busy_next = busy_vec[rd_addr] & ~w_hit;
        end
    end

    // Registered read result; held while the port is idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
            r_rd_busy <= 1'b0;
        end else if (rd_en) begin
            r_rd_data <= w_data_next;
            r_rd_busy <= w_busy_next;
        end
    end

    assign rd_data = r_rd_data;
    assign rd_busy = r_rd_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port integer register file with NUM_READ synchronous
//                read ports, NUM_WRITE write ports, optional write-to-read
//                bypass and a per-register busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import copperv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int REG_WIDTH  = c_default_reg_width,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    parameter int REG_LENGTH = 2 ** REG_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*REG_WIDTH-1:0]  wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_READ-1:0]             rd_en,
    input  logic [NUM_READ*REG_WIDTH-1:0]   rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic                            busy_set_en,
    input  logic [REG_WIDTH-1:0]            busy_set_addr,
    output logic [REG_LENGTH-1:0]           busy_vec
);

    logic [DATA_WIDTH-1:0]            r_mem [REG_LENGTH];
    logic [REG_LENGTH*DATA_WIDTH-1:0] w_mem_flat;
    logic [REG_LENGTH-1:0]            r_busy_vec;
    logic [REG_LENGTH-1:0]            w_busy_next;

    // Flatten the storage array so each read port can index it as one bus
    for (genvar i = 0; i < REG_LENGTH; i++) begin : g_flat
        assign w_mem_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i];
    end

    // Register storage update; later write ports override earlier ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_LENGTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (wr_en[k] &&
                    !((ZERO_REG != 0) && (wr_addr[reg_idx(k, REG_WIDTH) +: REG_WIDTH] == '0))) begin
                    r_mem[wr_addr[reg_idx(k, REG_WIDTH) +: REG_WIDTH]] <=
                        wr_data[reg_idx(k, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

    // Scoreboard next state: writes clear first, then a new producer sets
    always_comb begin
        w_busy_next = r_busy_vec;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_en[k]) begin
                w_busy_next[wr_addr[reg_idx(k, REG_WIDTH) +: REG_WIDTH]] = 1'b0;
            end
        end
        if (busy_set_en && !((ZERO_REG != 0) && (busy_set_addr == '0))) begin
            w_busy_next[busy_set_addr] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy_vec <= '0;
        end else begin
            r_busy_vec <= w_busy_next;
        end
    end

    assign busy_vec = r_busy_vec;

    for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_WIDTH  (REG_WIDTH),
            .REG_LENGTH (REG_LENGTH),
            .NUM_WRITE  (NUM_WRITE),
            .BYPASS     (BYPASS),
            .ZERO_REG   (ZERO_REG)
        ) u_rd (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[j]),
            .rd_addr  (rd_addr[j*REG_WIDTH +: REG_WIDTH]),
            .mem_flat (w_mem_flat),
            .busy_vec (r_busy_vec),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .rd_busy  (rd_busy[j])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed self-checking bench for regfile_mp. Two instances
//                share all inputs: one with bypass, one without, both with two
//                write ports, two read ports and register 0 hardwired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int c_dw = 32;
    localparam int c_rw = 5;
    localparam int c_nr = 2;
    localparam int c_nw = 2;
    localparam int c_rl = 32;

    logic                 clk;
    logic                 rst;
    logic [c_nw-1:0]      wr_en;
    logic [c_nw*c_rw-1:0] wr_addr;
    logic [c_nw*c_dw-1:0] wr_data;
    logic [c_nr-1:0]      rd_en;
    logic [c_nr*c_rw-1:0] rd_addr;
    logic                 busy_set_en;
    logic [c_rw-1:0]      busy_set_addr;

    logic [c_nr*c_dw-1:0] rd_data_b, rd_data_n;
    logic [c_nr-1:0]      rd_busy_b, rd_busy_n;
    logic [c_rl-1:0]      busy_vec_b, busy_vec_n;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .DATA_WIDTH (c_dw), .REG_WIDTH (c_rw), .NUM_READ (c_nr),
        .NUM_WRITE  (c_nw), .BYPASS (1), .ZERO_REG (1)
    ) u_dut_byp (
        .clk (clk), .rst (rst),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data_b), .rd_busy (rd_busy_b),
        .busy_set_en (busy_set_en), .busy_set_addr (busy_set_addr),
        .busy_vec (busy_vec_b)
    );

    regfile_mp #(
        .DATA_WIDTH (c_dw), .REG_WIDTH (c_rw), .NUM_READ (c_nr),
        .NUM_WRITE  (c_nw), .BYPASS (0), .ZERO_REG (1)
    ) u_dut_nob (
        .clk (clk), .rst (rst),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data_n), .rd_busy (rd_busy_n),
        .busy_set_en (busy_set_en), .busy_set_addr (busy_set_addr),
        .busy_vec (busy_vec_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en[port] = 1'b1;
        wr_addr[port*c_rw +: c_rw] = a;
        wr_data[port*c_dw +: c_dw] = d;
    endtask

    task automatic rd(input int port, input logic [4:0] a);
        rd_en[port] = 1'b1;
        rd_addr[port*c_rw +: c_rw] = a;
    endtask

    // Advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // 1. Reset after some writes and busy marks
        wr(0, 5'd5, 32'h1111_1111); wr(1, 5'd6, 32'h2222_2222);
        busy_set_en = 1'b1; busy_set_addr = 5'd6;
        step();
        idle();
        rst = 1'b0;
        rd(0, 5'd5); rd(1, 5'd6);
        wr(0, 5'd8, 32'hABCD_0000); busy_set_en = 1'b1; busy_set_addr = 5'd8;
        step();
        step();
        chk("rst_rd0", rd_data_b[31:0], 32'h0);
        chk("rst_busyvec", busy_vec_b, 32'h0);
        chk("rst_rdbusy", {30'd0, rd_busy_b}, 32'h0);
        idle();
        rst = 1'b1;
        rd(0, 5'd5); rd(1, 5'd8);
        step();
        chk("rst_mem_r5", rd_data_b[31:0], 32'h0);
        chk("rst_mem_r8", rd_data_n[63:32], 32'h0);
        chk("rst_busyvec2", busy_vec_n, 32'h0);

        // 2. Basic write then read
        idle(); wr(0, 5'd5, 32'hDEAD_BEEF);
        step();
        idle(); rd(0, 5'd5); rd(1, 5'd0);
        step();
        chk("basic_r5_byp", rd_data_b[31:0], 32'hDEAD_BEEF);
        chk("basic_r5_nob", rd_data_n[31:0], 32'hDEAD_BEEF);
        chk("basic_r0", rd_data_b[63:32], 32'h0);

        // 3. Bypass vs no bypass
        idle(); wr(0, 5'd7, 32'h55);
        step();
        idle(); wr(0, 5'd7, 32'h1234); rd(0, 5'd7);
        step();
        chk("bypass_on", rd_data_b[31:0], 32'h1234);
        chk("bypass_off", rd_data_n[31:0], 32'h55);

        // 4. Zero register ignores writes and busy marks
        idle(); wr(0, 5'd0, 32'hFFFF_FFFF); busy_set_en = 1'b1; busy_set_addr = 5'd0;
        step();
        chk("zero_busyvec", busy_vec_b, 32'h0);
        idle(); rd(0, 5'd0); rd(1, 5'd0);
        step();
        chk("zero_rd0", rd_data_b[31:0], 32'h0);
        chk("zero_rd1_nob", rd_data_n[63:32], 32'h0);
        chk("zero_rdbusy", {30'd0, rd_busy_b}, 32'h0);

        // 5. Scoreboard
        idle(); busy_set_en = 1'b1; busy_set_addr = 5'd3;
        step();
        chk("sb_set", busy_vec_b, 32'h0000_0008);
        idle(); rd(0, 5'd3);
        step();
        chk("sb_rdbusy", {31'd0, rd_busy_b[0]}, 32'h1);
        idle(); wr(0, 5'd3, 32'h33); busy_set_en = 1'b1; busy_set_addr = 5'd3; rd(1, 5'd3);
        step();
        chk("sb_setwins", busy_vec_b, 32'h0000_0008);
        chk("sb_byp_notbusy", {31'd0, rd_busy_b[1]}, 32'h0);
        chk("sb_byp_data", rd_data_b[63:32], 32'h33);
        chk("sb_nob_data", rd_data_n[63:32], 32'h0);
        chk("sb_hold_busy0", {31'd0, rd_busy_b[0]}, 32'h1);
        idle(); wr(1, 5'd3, 32'h44);
        step();
        chk("sb_clear", busy_vec_n, 32'h0);

        // 6. Two write ports to the same register
        idle(); wr(0, 5'd9, 32'hA); wr(1, 5'd9, 32'hB); rd(0, 5'd9);
        step();
        chk("dual_byp", rd_data_b[31:0], 32'hB);
        chk("dual_nob_old", rd_data_n[31:0], 32'h0);
        idle(); rd_addr[4:0] = 5'd5;
        step();
        chk("hold_byp", rd_data_b[31:0], 32'hB);
        chk("hold_nob", rd_data_n[31:0], 32'h0);
        idle(); rd(0, 5'd9); rd(1, 5'd3);
        step();
        chk("dual_mem", rd_data_n[31:0], 32'hB);
        chk("r3_final", rd_data_b[63:32], 32'h44);

        // 7. Reset mid-operation discards same-cycle activity
        idle(); rst = 1'b0;
        wr(0, 5'd10, 32'h77); busy_set_en = 1'b1; busy_set_addr = 5'd10; rd(0, 5'd9);
        step();
        chk("midrst_rd", rd_data_b[31:0], 32'h0);
        chk("midrst_busy", busy_vec_b, 32'h0);
        idle(); rst = 1'b1; rd(0, 5'd10); rd(1, 5'd9);
        step();
        chk("midrst_r10", rd_data_b[31:0], 32'h0);
        chk("midrst_r9", rd_data_n[63:32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
